pid_hit_buffer: RTL and testbench

- Downstream consumer of one fine-time channel stage.
- Inputs per clk cycle:
  - the 32-bit leading-edge decode word (Result);
  - the Electron/Muon/Pion match pulses.
- Encodes each hit into a 32-bit word: fine time, coarse timestamp, PID flags, channel id.
- Buffers words in a 16-deep FIFO. The FIFO is drained over the shared local bus; DataOut is OR-combined with the other bus slaves.

---
 rtl/pid_hit_buffer.sv | 215 +++++++++++++++++++++
 tb/tb_pid_hit_buffer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_hit_buffer.sv
// pid_hit_buffer: encodes fine-time leading-edge hits with PID flags and a
// coarse timestamp into 32-bit words and buffers them in a 16-deep FIFO
// that is drained over the shared local bus.
// Optional build macro: PID_HIT_BUFFER_PIDONLY_EN (push only hits that carry
// at least one PID match).
module pid_hit_buffer #(
  parameter logic [5:0]  Ch        = 6'd0,
  parameter logic [7:0]  BASE_ADDR = 8'h80,
  parameter int unsigned PID_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Result,
  input  logic        Electron,
  input  logic        Muon,
  input  logic        Pion,
  input  logic [31:0] DataIn,
  input  logic [7:0]  Address,
  input  logic        Read,
  input  logic        Write,
  output logic [31:0] DataOut,
  output logic        hit_pending
);

  localparam logic [7:0] STAT_ADDR = BASE_ADDR + 8'd1;
  localparam logic [7:0] CTRL_ADDR = BASE_ADDR + 8'd2;

  logic [15:0] coarse;
  logic [31:0] dly_result;
  logic [15:0] dly_coarse;

  logic [31:0] enc_result;
  logic [15:0] enc_coarse;
  logic [2:0]  enc_pid;

  logic [4:0]  fine;
  logic        found;
  logic        multi;
  logic [31:0] hit_word;
  logic        push_req;

  logic [31:0] mem [16];
  logic [3:0]  wptr;
  logic [3:0]  rptr;
  logic [4:0]  count;
  logic [4:0]  count_next;
  logic        empty;
  logic        full;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        enable;
  logic        read_q;

  logic        data_hit;
  logic        stat_hit;
  logic        ctrl_hit;
  logic        ctrl_wr;
  logic        flush;
  logic        clr;
  logic        pop_req;
  logic        do_pop;
  logic        do_push;
  logic        drop;
  logic [31:0] status;

  // Free-running coarse timestamp, wraps naturally
  always_ff @(posedge clk) begin
    if (rst) coarse <= '0;
    else     coarse <= coarse + 16'd1;
  end

  // Delay Result and its timestamp so they line up with the PID pulses
  if (PID_DELAY == 0) begin : g_nodly
    assign dly_result = Result;
    assign dly_coarse = coarse;
  end else begin : g_dly
    logic [31:0] res_pipe [PID_DELAY];
    logic [15:0] crs_pipe [PID_DELAY];
    for (genvar g = 0; g < PID_DELAY; g++) begin : g_stage
      if (g == 0) begin : g_first
        // First delay stage samples the live inputs
        always_ff @(posedge clk) begin
          if (rst) begin
            res_pipe[g] <= '0;
            crs_pipe[g] <= '0;
          end else begin
            res_pipe[g] <= Result;
            crs_pipe[g] <= coarse;
          end
        end
      end else begin : g_next
        // Later stages shift the previous stage along
        always_ff @(posedge clk) begin
          if (rst) begin
            res_pipe[g] <= '0;
            crs_pipe[g] <= '0;
          end else begin
            res_pipe[g] <= res_pipe[g-1];
            crs_pipe[g] <= crs_pipe[g-1];
          end
        end
      end
    end
    assign dly_result = res_pipe[PID_DELAY-1];
    assign dly_coarse = crs_pipe[PID_DELAY-1];
  end

  // Encode stage: aligned Result/timestamp together with the current PID pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_result <= '0;
      enc_coarse <= '0;
      enc_pid    <= '0;
    end else begin
      enc_result <= dly_result;
      enc_coarse <= dly_coarse;
      enc_pid    <= {Pion, Muon, Electron};
    end
  end

  // Lowest set bit gives the fine time; multi flags more than one edge
  always_comb begin
    fine  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (enc_result[i] && !found) begin
        fine  = 5'(i);
        found = 1'b1;
      end
    end
    multi    = |(enc_result & (enc_result - 32'd1));
    hit_word = {1'b1, multi, enc_pid, Ch, enc_coarse, fine};
`ifdef PID_HIT_BUFFER_PIDONLY_EN
    push_req = enable && (enc_result != '0) && (enc_pid != '0);
`else
    push_req = enable && (enc_result != '0);
`endif
  end

  // Bus decode and FIFO push/pop/drop arbitration
  always_comb begin
    data_hit = (Address == BASE_ADDR);
    stat_hit = (Address == STAT_ADDR);
    ctrl_hit = (Address == CTRL_ADDR);
    ctrl_wr  = Write && ctrl_hit;
    flush    = ctrl_wr && DataIn[1];
    clr      = ctrl_wr && DataIn[2];
    empty    = (count == 5'd0);
    full     = (count == 5'd16);
    pop_req  = Read && !read_q && data_hit;
    // A flush swallows both the pop and any push landing on the same edge
    do_pop   = pop_req && !empty && !flush;
    do_push  = push_req && !flush && (!full || do_pop);
    drop     = push_req && !flush && full && !do_pop;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count_next = count + 5'd1;
        2'b01:   count_next = count - 5'd1;
        default: count_next = count;
      endcase
    end
    status = {drop_cnt, 7'b0, overflow, 6'b0, full, empty, 3'b0, count};
  end

  // FIFO pointers, occupancy, error flags and control register
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      hit_pending <= 1'b0;
      overflow    <= 1'b0;
      drop_cnt    <= '0;
      enable      <= 1'b1;
      read_q      <= 1'b0;
    end else begin
      read_q      <= Read;
      count       <= count_next;
      hit_pending <= (count_next != 5'd0);
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (do_push) wptr <= wptr + 4'd1;
        if (do_pop)  rptr <= rptr + 4'd1;
      end
      if (ctrl_wr) enable <= DataIn[0];
      if (clr) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wptr] <= hit_word;
  end

  // Read mux; idle bus contributes zero to the OR-combined data lines
  always_comb begin
    DataOut = '0;
    if (Read) begin
      if (data_hit)      DataOut = empty ? '0 : mem[rptr];
      else if (stat_hit) DataOut = status;
      else if (ctrl_hit) DataOut = {31'b0, enable};
    end
  end

endmodule

// File: tb/tb_pid_hit_buffer.sv
// Directed self-checking bench for pid_hit_buffer (default parameters).
module tb_pid_hit_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] Result;
  logic        Electron;
  logic        Muon;
  logic        Pion;
  logic [31:0] DataIn;
  logic [7:0]  Address;
  logic        Read;
  logic        Write;
  logic [31:0] DataOut;
  logic        hit_pending;

  int checks;
  int failures;

  pid_hit_buffer #(.Ch(6'd0), .BASE_ADDR(8'h80), .PID_DELAY(1)) dut (
    .clk(clk), .rst(rst), .Result(Result), .Electron(Electron), .Muon(Muon),
    .Pion(Pion), .DataIn(DataIn), .Address(Address), .Read(Read), .Write(Write),
    .DataOut(DataOut), .hit_pending(hit_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Combinational look at a register without creating a Read rising edge at an edge
  task automatic peek(input logic [7:0] a, output logic [31:0] d);
    Address = a;
    Read = 1'b1;
    #1;
    d = DataOut;
    Read = 1'b0;
    Address = 8'h00;
  endtask

  // Full read transaction; pops when addressed at the data register
  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    Address = a;
    Read = 1'b1;
    #1;
    d = DataOut;
    tick();
    Read = 1'b0;
    Address = 8'h00;
    tick();
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    Address = a;
    DataIn = d;
    Write = 1'b1;
    tick();
    Write = 1'b0;
    DataIn = '0;
    Address = 8'h00;
  endtask

  // One hit; PID pulses follow one cycle later; returns after the push edge
  task automatic push_hit(input logic [31:0] r, input logic [2:0] pid);
    Result = r;
    {Pion, Muon, Electron} = 3'b000;
    tick();
    Result = '0;
    {Pion, Muon, Electron} = pid;
    tick();
    {Pion, Muon, Electron} = 3'b000;
    tick();
  endtask

  // Back-to-back hits 1<<i, Pion held high throughout
  task automatic burst(input int n);
    Pion = 1'b1;
    for (int i = 0; i < n; i++) begin
      Result = 32'd1 << i;
      tick();
    end
    Result = '0;
    tick();
    tick();
    Pion = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    checks++;
    if (hit_pending !== 1'b0) begin
      failures++; $display("FAIL reset_pending got=%0b exp=0", hit_pending);
    end
    peek(8'h81, d);
    checks++;
    if (d !== 32'h0000_0100) begin
      failures++; $display("FAIL reset_status got=%h exp=00000100", d);
    end
    peek(8'h82, d);
    checks++;
    if (d !== 32'h0000_0001) begin
      failures++; $display("FAIL reset_ctrl got=%h exp=00000001", d);
    end
    Address = 8'h81;
    #1;
    checks++;
    if (DataOut !== 32'h0) begin
      failures++; $display("FAIL idle_bus got=%h exp=00000000", DataOut);
    end
    peek(8'h83, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL unmapped_read got=%h exp=00000000", d);
    end
  endtask

  task automatic test_basic_hit();
    logic [31:0] d;
    do_reset();
    repeat (16) tick();
    Result = 32'h0000_0100;
    tick();
    Result = '0;
    Electron = 1'b1;
    tick();
    Electron = 1'b0;
    checks++;
    if (hit_pending !== 1'b0) begin
      failures++; $display("FAIL latency_early got=%0b exp=0", hit_pending);
    end
    tick();
    checks++;
    if (hit_pending !== 1'b1) begin
      failures++; $display("FAIL latency_pending got=%0b exp=1", hit_pending);
    end
    peek(8'h81, d);
    checks++;
    if (d !== 32'h0000_0001) begin
      failures++; $display("FAIL basic_count got=%h exp=00000001", d);
    end
    bus_read(8'h80, d);
    checks++;
    if (d !== 32'h8800_0208) begin
      failures++; $display("FAIL basic_word got=%h exp=88000208", d);
    end
    bus_read(8'h80, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL empty_read got=%h exp=00000000", d);
    end
  endtask

  task automatic test_multi();
    logic [31:0] d;
    do_reset();
    push_hit(32'h0001_0004, 3'b000);
`ifdef PID_HIT_BUFFER_PIDONLY_EN
    peek(8'h81, d);
    checks++;
    if (d !== 32'h0000_0100) begin
      failures++; $display("FAIL pidonly_discard got=%h exp=00000100", d);
    end
`else
    bus_read(8'h80, d);
    checks++;
    if ((d & 32'hFFE0_001F) !== 32'hC000_0002) begin
      failures++; $display("FAIL multi_word got=%h exp_masked=C0000002", d);
    end
`endif
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    do_reset();
    burst(17);
    peek(8'h81, d);
    checks++;
    if (d !== 32'h0101_0210) begin
      failures++; $display("FAIL overflow_status got=%h exp=01010210", d);
    end
    checks++;
    if (hit_pending !== 1'b1) begin
      failures++; $display("FAIL full_pending got=%0b exp=1", hit_pending);
    end
    bus_write(8'h82, 32'h4);
    peek(8'h81, d);
    checks++;
    if (d !== 32'h0000_0210) begin
      failures++; $display("FAIL clear_status got=%h exp=00000210", d);
    end
    peek(8'h82, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL ctrl_readback got=%h exp=00000000", d);
    end
    bus_write(8'h82, 32'h1);
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d;
    logic [31:0] exp;
    Result = 32'd1 << 20;
    Pion = 1'b1;
    tick();
    Result = '0;
    tick();
    Address = 8'h80;
    Read = 1'b1;
    #1;
    checks++;
    if ((DataOut & 32'hE000_001F) !== 32'hA000_0000) begin
      failures++; $display("FAIL pushpop_oldest got=%h exp_masked=A0000000", DataOut);
    end
    tick();
    Read = 1'b0;
    Pion = 1'b0;
    Address = 8'h00;
    tick();
    peek(8'h81, d);
    checks++;
    if (d !== 32'h0000_0210) begin
      failures++; $display("FAIL pushpop_count got=%h exp=00000210", d);
    end
    for (int i = 0; i < 16; i++) begin
      exp = 32'hA000_0000 | ((i < 15) ? 32'(i + 1) : 32'd20);
      bus_read(8'h80, d);
      checks++;
      if ((d & 32'hE000_001F) !== exp) begin
        failures++; $display("FAIL drain_%0d got=%h exp_masked=%h", i, d, exp);
      end
    end
    peek(8'h81, d);
    checks++;
    if (d !== 32'h0000_0100) begin
      failures++; $display("FAIL drain_status got=%h exp=00000100", d);
    end
  endtask

  task automatic test_hold_read();
    logic [31:0] d;
    do_reset();
    burst(3);
    peek(8'h81, d);
    checks++;
    if (d !== 32'h0000_0003) begin
      failures++; $display("FAIL hold_pre got=%h exp=00000003", d);
    end
    Address = 8'h80;
    Read = 1'b1;
    repeat (5) tick();
    Read = 1'b0;
    Address = 8'h00;
    tick();
    peek(8'h81, d);
    checks++;
    if (d !== 32'h0000_0002) begin
      failures++; $display("FAIL hold_single_pop got=%h exp=00000002", d);
    end
    bus_read(8'h80, d);
    checks++;
    if ((d & 32'hFFE0_001F) !== 32'hA000_0001) begin
      failures++; $display("FAIL hold_next_word got=%h exp_masked=A0000001", d);
    end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    burst(3);
    peek(8'h81, d);
    checks++;
    if (d !== 32'h0000_0004) begin
      failures++; $display("FAIL flush_pre got=%h exp=00000004", d);
    end
    Result = 32'h8;
    Electron = 1'b1;
    tick();
    Result = '0;
    tick();
    Address = 8'h82;
    DataIn = 32'h3;
    Write = 1'b1;
    tick();
    Write = 1'b0;
    Electron = 1'b0;
    DataIn = '0;
    Address = 8'h00;
    tick();
    peek(8'h81, d);
    checks++;
    if (d !== 32'h0000_0100) begin
      failures++; $display("FAIL flush_status got=%h exp=00000100", d);
    end
    peek(8'h82, d);
    checks++;
    if (d !== 32'h0000_0001) begin
      failures++; $display("FAIL flush_ctrl got=%h exp=00000001", d);
    end
  endtask

  task automatic test_disable_and_reset();
    logic [31:0] d;
    do_reset();
    burst(17);
    bus_write(8'h82, 32'h0);
    push_hit(32'h10, 3'b100);
    peek(8'h81, d);
    checks++;
    if (d !== 32'h0101_0210) begin
      failures++; $display("FAIL disable_nopush got=%h exp=01010210", d);
    end
    bus_read(8'h80, d);
    checks++;
    if ((d & 32'h8000_001F) !== 32'h8000_0000) begin
      failures++; $display("FAIL disable_drain got=%h exp_masked=80000000", d);
    end
    peek(8'h81, d);
    checks++;
    if (d !== 32'h0101_000F) begin
      failures++; $display("FAIL disable_count got=%h exp=0101000F", d);
    end
    Address = 8'h80;
    Read = 1'b1;
    #1;
    checks++;
    if (DataOut[31] !== 1'b1) begin
      failures++; $display("FAIL preread_valid got=%0b exp=1", DataOut[31]);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (DataOut !== 32'h0) begin
      failures++; $display("FAIL reset_read got=%h exp=00000000", DataOut);
    end
    checks++;
    if (hit_pending !== 1'b0) begin
      failures++; $display("FAIL reset_read_pending got=%0b exp=0", hit_pending);
    end
    rst = 1'b0;
    Read = 1'b0;
    Address = 8'h00;
    peek(8'h81, d);
    checks++;
    if (d !== 32'h0000_0100) begin
      failures++; $display("FAIL reset_read_status got=%h exp=00000100", d);
    end
    peek(8'h82, d);
    checks++;
    if (d !== 32'h0000_0001) begin
      failures++; $display("FAIL reset_enable got=%h exp=00000001", d);
    end
    push_hit(32'h8000_0000, 3'b010);
    bus_read(8'h80, d);
    checks++;
    if (d !== 32'h9000_001F) begin
      failures++; $display("FAIL coarse_zero got=%h exp=9000001F", d);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    Result = '0;
    Electron = 1'b0;
    Muon = 1'b0;
    Pion = 1'b0;
    DataIn = '0;
    Address = 8'h00;
    Read = 1'b0;
    Write = 1'b0;
    test_reset();
    test_basic_hit();
    test_multi();
    test_overflow();
    test_full_push_pop();
    test_hold_read();
    test_flush();
    test_disable_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
